// File: rtl/cache_tag_compare_if.sv
// ---------------------------------------------------------------------------
// cache_tag_compare_if
//   Bundles the handshake and data signals around the tag-compare stage of the
//   inter-prediction reference cache.
//   - request side : valid_in / tag_compare_stage_ready, block coordinate,
//                    sideband change flags, flush
//   - result side  : out_valid / out_ready, hit, way, set, sideband copies
//   - fill side    : fill_req_valid / fill_req_ready, address, victim way,
//                    fill_done pulse
//   modport master : the environment (upstream, downstream and fill engine)
//   modport slave  : the tag-compare stage itself
// ---------------------------------------------------------------------------
interface cache_tag_compare_if #(
  parameter int XA_W       = 7,
  parameter int YA_W       = 7,
  parameter int REF_W      = 4,
  parameter int SET_X_BITS = 2,
  parameter int SET_Y_BITS = 3,
  parameter int WAY_BITS   = 2
);
  localparam int SET_W  = SET_X_BITS + SET_Y_BITS;
  localparam int ADDR_W = REF_W + YA_W + XA_W;

  // Request from the set-input stage
  logic              valid_in;
  logic              tag_compare_stage_ready;
  logic [XA_W-1:0]   curr_x_addr;
  logic [YA_W-1:0]   curr_y_addr;
  logic [REF_W-1:0]  ref_idx;
  logic              cur_xy_changed_luma;
  logic              cur_xy_changed_chma;
  logic              flush;

  // Result to the data-fetch stage
  logic              out_valid;
  logic              out_ready;
  logic              out_hit;
  logic [WAY_BITS-1:0] out_way;
  logic [SET_W-1:0]  out_set;
  logic              out_changed_luma;
  logic              out_changed_chma;

  // Miss fill request
  logic              fill_req_valid;
  logic              fill_req_ready;
  logic [ADDR_W-1:0] fill_req_addr;
  logic [WAY_BITS-1:0] fill_req_way;
  logic              fill_done;

  modport master (
    output valid_in, curr_x_addr, curr_y_addr, ref_idx,
           cur_xy_changed_luma, cur_xy_changed_chma, flush,
           out_ready, fill_req_ready, fill_done,
    input  tag_compare_stage_ready, out_valid, out_hit, out_way, out_set,
           out_changed_luma, out_changed_chma,
           fill_req_valid, fill_req_addr, fill_req_way
  );

  modport slave (
    input  valid_in, curr_x_addr, curr_y_addr, ref_idx,
           cur_xy_changed_luma, cur_xy_changed_chma, flush,
           out_ready, fill_req_ready, fill_done,
    output tag_compare_stage_ready, out_valid, out_hit, out_way, out_set,
           out_changed_luma, out_changed_chma,
           fill_req_valid, fill_req_addr, fill_req_way
  );
endinterface

// File: rtl/cache_tag_compare.sv
// ---------------------------------------------------------------------------
// cache_tag_compare
//   Tag lookup stage of the inter-prediction reference cache. Each accepted
//   block coordinate is looked up in a flop-based 4-way set-associative tag
//   store. A hit is reported one cycle after acceptance. A miss raises a fill
//   request for the round-robin victim way, waits for fill_done, writes the
//   tag and reports the (now resident) block with out_hit = 0.
//
//   Ports
//     clk    : clock
//     reset  : synchronous active-high reset
//     bus    : cache_tag_compare_if.slave (request, result and fill channels)
// ---------------------------------------------------------------------------
module cache_tag_compare #(
  parameter int XA_W       = 7,
  parameter int YA_W       = 7,
  parameter int REF_W      = 4,
  parameter int SET_X_BITS = 2,
  parameter int SET_Y_BITS = 3,
  parameter int WAY_BITS   = 2
) (
  input  logic               clk,
  input  logic               reset,
  cache_tag_compare_if.slave bus
);

  localparam int SET_W    = SET_X_BITS + SET_Y_BITS;
  localparam int NUM_SETS = 1 << SET_W;
  localparam int NUM_WAYS = 1 << WAY_BITS;
  localparam int TAG_W    = REF_W + (YA_W - SET_Y_BITS) + (XA_W - SET_X_BITS);
  localparam int ADDR_W   = REF_W + YA_W + XA_W;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_e;

  // ---------------------------------------------------------------- state
  state_e                state_q, state_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [WAY_BITS-1:0]   rr_q    [NUM_SETS];
  logic [WAY_BITS-1:0]   rr_d    [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];

  logic                  flush_pend_q, flush_pend_d;

  // Miss context, captured when the missing request is accepted
  logic [SET_W-1:0]      miss_set_q, miss_set_d;
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic                  miss_luma_q, miss_luma_d;
  logic                  miss_chma_q, miss_chma_d;
  logic [ADDR_W-1:0]     fill_req_addr_q, fill_req_addr_d;
  logic [WAY_BITS-1:0]   fill_req_way_q, fill_req_way_d;

  // Result register
  logic                  out_valid_q, out_valid_d;
  logic                  out_hit_q, out_hit_d;
  logic [WAY_BITS-1:0]   out_way_q, out_way_d;
  logic [SET_W-1:0]      out_set_q, out_set_d;
  logic                  out_luma_q, out_luma_d;
  logic                  out_chma_q, out_chma_d;

  // ---------------------------------------------------------------- lookup
  logic [SET_W-1:0]      lk_set;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [WAY_BITS-1:0]   lk_way;

  assign lk_set = {bus.curr_y_addr[SET_Y_BITS-1:0], bus.curr_x_addr[SET_X_BITS-1:0]};
  assign lk_tag = {bus.ref_idx,
                   bus.curr_y_addr[YA_W-1:SET_Y_BITS],
                   bus.curr_x_addr[XA_W-1:SET_X_BITS]};

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin : lookup
    lk_hit = 1'b0;
    lk_way = '0;
    // Ways never hold duplicate tags, so at most one way can match.
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_BITS'(w);
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  logic stage_ready;
  logic fill_req_valid;
  logic accept;
  logic fill_write;

  assign accept     = bus.valid_in && stage_ready;
  // Reset wins over a coincident fill_done: an abandoned miss writes nothing.
  assign fill_write = (state_q == S_MISS_WAIT) && bus.fill_done && !reset;

  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      S_COMPARE:   if (accept && !lk_hit)     state_d = S_MISS_REQ;
      S_MISS_REQ:  if (bus.fill_req_ready)    state_d = S_MISS_WAIT;
      S_MISS_WAIT: if (bus.fill_done)         state_d = S_COMPARE;
      default:                                state_d = S_COMPARE;
    endcase
  end

  always_comb begin : fsm_out
    stage_ready    = 1'b0;
    fill_req_valid = 1'b0;
    if (!reset) begin
      unique case (state_q)
        // A pending flush blocks acceptance for the one cycle it is applied.
        S_COMPARE:  stage_ready = !bus.flush && !flush_pend_q &&
                                  (!out_valid_q || bus.out_ready);
        S_MISS_REQ: fill_req_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin : datapath
    valid_d         = valid_q;
    rr_d            = rr_q;
    flush_pend_d    = flush_pend_q;
    miss_set_d      = miss_set_q;
    miss_tag_d      = miss_tag_q;
    miss_luma_d     = miss_luma_q;
    miss_chma_d     = miss_chma_q;
    fill_req_addr_d = fill_req_addr_q;
    fill_req_way_d  = fill_req_way_q;
    out_valid_d     = out_valid_q;
    out_hit_d       = out_hit_q;
    out_way_d       = out_way_q;
    out_set_d       = out_set_q;
    out_luma_d      = out_luma_q;
    out_chma_d      = out_chma_q;

    if (fill_write) begin
      valid_d[miss_set_q][fill_req_way_q] = 1'b1;
      rr_d[miss_set_q] = rr_q[miss_set_q] + 1'b1;
    end

    // Flush only takes effect in COMPARE; during a miss it is remembered and
    // applied after the fill tag write so the pending miss still completes.
    if (state_q == S_COMPARE) begin
      if (bus.flush || flush_pend_q) begin
        for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
        flush_pend_d = 1'b0;
      end
    end else if (bus.flush) begin
      flush_pend_d = 1'b1;
    end

    if (accept && !lk_hit) begin
      miss_set_d      = lk_set;
      miss_tag_d      = lk_tag;
      miss_luma_d     = bus.cur_xy_changed_luma;
      miss_chma_d     = bus.cur_xy_changed_chma;
      fill_req_addr_d = {bus.ref_idx, bus.curr_y_addr, bus.curr_x_addr};
      fill_req_way_d  = rr_q[lk_set];
    end

    if (accept && lk_hit) begin
      out_valid_d = 1'b1;
      out_hit_d   = 1'b1;
      out_way_d   = lk_way;
      out_set_d   = lk_set;
      out_luma_d  = bus.cur_xy_changed_luma;
      out_chma_d  = bus.cur_xy_changed_chma;
    end else if (fill_write) begin
      out_valid_d = 1'b1;
      out_hit_d   = 1'b0;
      out_way_d   = fill_req_way_q;
      out_set_d   = miss_set_q;
      out_luma_d  = miss_luma_q;
      out_chma_d  = miss_chma_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_hit_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_COMPARE;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      flush_pend_q    <= 1'b0;
      miss_set_q      <= '0;
      miss_tag_q      <= '0;
      miss_luma_q     <= 1'b0;
      miss_chma_q     <= 1'b0;
      fill_req_addr_q <= '0;
      fill_req_way_q  <= '0;
      out_valid_q     <= 1'b0;
      out_hit_q       <= 1'b0;
      out_way_q       <= '0;
      out_set_q       <= '0;
      out_luma_q      <= 1'b0;
      out_chma_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      rr_q            <= rr_d;
      flush_pend_q    <= flush_pend_d;
      miss_set_q      <= miss_set_d;
      miss_tag_q      <= miss_tag_d;
      miss_luma_q     <= miss_luma_d;
      miss_chma_q     <= miss_chma_d;
      fill_req_addr_q <= fill_req_addr_d;
      fill_req_way_q  <= fill_req_way_d;
      out_valid_q     <= out_valid_d;
      out_hit_q       <= out_hit_d;
      out_way_q       <= out_way_d;
      out_set_q       <= out_set_d;
      out_luma_q      <= out_luma_d;
      out_chma_q      <= out_chma_d;
    end
  end

  // NOTE: the tag array has no reset; its contents are only observed through
  // the valid bits, which are reset.
  always_ff @(posedge clk) begin
    if (fill_write) tag_q[miss_set_q][fill_req_way_q] <= miss_tag_q;
  end

  // ---------------------------------------------------------------- outputs
  assign bus.tag_compare_stage_ready = stage_ready;
  assign bus.fill_req_valid          = fill_req_valid;
  assign bus.fill_req_addr           = fill_req_addr_q;
  assign bus.fill_req_way            = fill_req_way_q;
  assign bus.out_valid               = out_valid_q;
  assign bus.out_hit                 = out_hit_q;
  assign bus.out_way                 = out_way_q;
  assign bus.out_set                 = out_set_q;
  assign bus.out_changed_luma        = out_luma_q;
  assign bus.out_changed_chma        = out_chma_q;

endmodule

// File: doc/cache_tag_compare.md
Name: cache_tag_compare

Overview:
- Stage directly downstream of the cache set-input stage in the inter-prediction reference cache.
- Accepts one block coordinate per handshake (curr_x_addr, curr_y_addr, ref_idx) and looks it up in a flop-based, set-associative tag store.
- Reports hit or miss plus the way index to the data-fetch stage; on a miss it issues a fill request and blocks until the fill completes.

Parameters:
XA_W, 7, width of curr_x_addr
YA_W, 7, width of curr_y_addr
REF_W, 4, width of ref_idx
SET_X_BITS, 2, low x-address bits used in set index
SET_Y_BITS, 3, low y-address bits used in set index
WAY_BITS, 2, log2 of associativity (4 ways)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_in  in  1  upstream valid (set_input_stage_valid)
tag_compare_stage_ready  out  1  ready to upstream
curr_x_addr  in  XA_W  block x address
curr_y_addr  in  YA_W  block y address
ref_idx  in  REF_W  reference picture index
cur_xy_changed_luma  in  1  sideband, passed through with the accepted request
cur_xy_changed_chma  in  1  sideband, passed through with the accepted request
flush  in  1  invalidate all entries (new picture)
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_hit  out  1  1 = hit, 0 = miss that has been filled
out_way  out  WAY_BITS  way holding the block
out_set  out  SET_X_BITS+SET_Y_BITS  set index
out_changed_luma  out  1  registered copy of cur_xy_changed_luma
out_changed_chma  out  1  registered copy of cur_xy_changed_chma
fill_req_valid  out  1  miss fill request
fill_req_ready  in  1  fill request accepted
fill_req_addr  out  REF_W+YA_W+XA_W  {ref_idx, y, x}
fill_req_way  out  WAY_BITS  victim way
fill_done  in  1  one-cycle pulse: fill data written

Behaviour:
- Reset: all valid bits 0; all round-robin pointers 0; state COMPARE; tag_compare_stage_ready, out_valid, out_hit, fill_req_valid = 0; out_way, out_set, out_changed_*, fill_req_addr, fill_req_way = 0. Reset mid-miss abandons the miss with no tag write.
- Indexing: set = {curr_y_addr[SET_Y_BITS-1:0], curr_x_addr[SET_X_BITS-1:0]}; tag = {ref_idx, curr_y_addr[YA_W-1:SET_Y_BITS], curr_x_addr[XA_W-1:SET_X_BITS]}.
- Hit condition: any way with valid=1 and a matching tag. Ways never hold duplicate tags.
- States: COMPARE, MISS_REQ, MISS_WAIT.
- COMPARE:
  - tag_compare_stage_ready = !flush && (!out_valid || out_ready), combinational.
  - Accept = valid_in && ready.
  - Hit: next cycle out_valid=1, out_hit=1, out_way = matching way. Latency is 1 cycle.
  - Miss: latch set, tag and sideband; victim = rr_ptr[set]; go to MISS_REQ with fill_req_valid=1 next cycle.
- MISS_REQ: hold fill_req_valid, fill_req_addr and fill_req_way stable until fill_req_ready; then go to MISS_WAIT. Ready = 0.
- MISS_WAIT: ready = 0. On fill_done:
  - write tag, set valid=1 for the victim way, and increment rr_ptr[set] (wraps 3->0);
  - next cycle out_valid=1, out_hit=0, out_way = victim;
  - return to COMPARE.
- fill_done before fill_req_ready is ignored.
- Output register: holds stable while out_valid && !out_ready; clears when out_ready && no new result.
- Tag write vs. lookup: a request accepted the cycle after the fill sees the updated tag, so there is no bypass.
- flush:
  - In COMPARE, flush clears all valid bits next cycle and blocks acceptance that cycle; rr pointers are unchanged.
  - In MISS_REQ or MISS_WAIT, flush is held pending and applied on the cycle after return to COMPARE, after the fill tag write. The pending miss still completes and is reported.
- Simultaneous flush and valid_in: flush wins; the request waits.

Test Plan:
- Cold miss: reset; send x=5, y=9, ref=2 -> set=0b001_01; fill_req_addr={2,9,5}, way 0; fill_req_ready pulse, then fill_done -> out_valid with hit=0, way=0.
- Re-hit: resend the same coordinate -> out_valid exactly 1 cycle after accept, hit=1, way=0, no fill_req.
- Replacement: five distinct tags in set 0 (x=0, y=0/8/16/24/32) -> victims 0,1,2,3,0; the first tag then misses again.
- Backpressure: hold out_ready=0 after a hit -> ready=0, out fields stable for 5 cycles; release -> next request accepted same cycle.
- Flush: hit-filled entry, pulse flush -> same coordinate misses. Flush during MISS_WAIT -> miss reported hit=0, then that coordinate misses again.
- Reset in MISS_WAIT: fill_req_valid=0, ready=0 during reset; after reset the coordinate misses and uses way 0.
